// File: rtl/mult_sequencer.sv
// Shift-add multiply sequencer for the execute stage: borrows the shared ALU for
// one add per iteration, owns HI/LO, and reports busy/stall to the hazard unit.
module mult_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ALU_ADD = 3'b010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hilo_rd,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a level request sampled only in IDLE; the requester
  // holds the pipeline while stall is high, and hi/lo are valid while done
  // pulses (and hold afterwards). abort drops the operation with no done.

  localparam int          CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int          MSB  = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               neg_q, neg_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   abs_a, abs_b, addend;
  logic               carry;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Magnitude of the most negative value wraps to itself, read as unsigned.
  assign abs_a = (sgn && src_a[MSB]) ? (-src_a) : src_a;
  assign abs_b = (sgn && src_b[MSB]) ? (-src_b) : src_b;

  assign addend = q_q[0] ? m_q : '0;
  // The shared ALU has no carry out, so rebuild it from the operand and sum MSBs.
  assign carry  = (p_q[MSB] & addend[MSB]) | ((p_q[MSB] | addend[MSB]) & ~alu_y[MSB]);

  assign prod     = {p_q, q_q};
  assign prod_fix = neg_q ? (-prod) : prod;

  assign alu_own   = (state_q == S_ITER);
  assign alu_a     = p_q;
  assign alu_b     = alu_own ? addend : '0;
  assign alu_f     = alu_own ? ALU_ADD : 3'b000;
  assign busy      = (state_q != S_IDLE);
  assign stall     = (start & ~busy) | busy | (hilo_rd & (busy | start));
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    m_d     = m_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          m_d     = abs_a;
          q_d     = abs_b;
          neg_d   = sgn & (src_a[MSB] ^ src_b[MSB]);
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          p_d   = {carry, alu_y[MSB:1]};
          q_d   = {alu_y[0], q_q[MSB:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          {hi_d, lo_d} = prod_fix;
          done_d       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Sequences the shift-add multiply in the execute stage. It borrows the shared execute-stage ALU for one add per iteration and owns the HI/LO result registers. It reports busy and stall status to the hazard unit. One multiply is in flight at a time. Signed operands are handled by magnitude multiplication followed by a 64-bit negate fix-up.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.
ALU_ADD, 3'b010, ALU function code driven on alu_f during iterations.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low; clears all state.
start  in  1  multiply request from the decode/execute control path, sampled only in IDLE.
sgn  in  1  1 = signed multiply, 0 = unsigned; sampled with start.
src_a  in  WIDTH  multiplicand, already forwarded; sampled with start.
src_b  in  WIDTH  multiplier, already forwarded; sampled with start.
abort  in  1  pipeline flush of the owning instruction.
hilo_rd  in  1  instruction in execute reads HI or LO.
alu_own  out  1  execute ALU input mux selects alu_a/alu_b/alu_f.
alu_a  out  WIDTH  ALU operand A = partial product P.
alu_b  out  WIDTH  ALU operand B = multiplicand magnitude M, or 0.
alu_f  out  3  ALU function code; ALU_ADD while alu_own is high, else 0.
alu_y  in  WIDTH  ALU result.
busy  out  1  high in every state except IDLE.
stall  out  1  hazard unit stall request.
done  out  1  one-cycle pulse; hi/lo newly valid.
hi  out  WIDTH  upper product word.
lo  out  WIDTH  lower product word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; P, Q, M, neg, cnt, hi, lo = 0; done=0. Consequently busy, alu_own, alu_f and stall = 0.
- States: IDLE, ITER, FIX.
- IDLE, start=1 at edge k:
  - M <= |src_a| when sgn=1, else src_a; Q <= |src_b| when sgn=1, else src_b.
  - neg <= sgn & (src_a[MSB] ^ src_b[MSB]).
  - P <= 0; cnt <= 0; state <= ITER.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- ITER:
  - alu_own=1, alu_a=P, alu_b = Q[0] ? M : 0, alu_f=ALU_ADD.
  - Carry is computed locally, because the ALU has no carry out: c = (P[MSB]&alu_b[MSB]) | ((P[MSB]|alu_b[MSB]) & ~alu_y[MSB]).
  - Each edge: P <= {c, alu_y[MSB:1]}; Q <= {alu_y[0], Q[MSB:1]}; cnt <= cnt+1.
  - When cnt==WIDTH-1, state <= FIX.
- FIX, one cycle:
  - {hi,lo} <= neg ? -{P,Q} (64-bit two's complement, computed locally) : {P,Q}.
  - done <= 1; state <= IDLE.
- done: registered, high exactly for the one cycle after the FIX edge; otherwise 0.
- Latency: start sampled at edge k; ITER spans edges k+1..k+WIDTH; FIX occupies edge k+WIDTH+1; done and new hi/lo are visible after that edge (34 cycles for WIDTH=32).
- busy: high from the edge after start through the FIX cycle inclusive.
- stall = (start & ~busy) | busy | (hilo_rd & (busy | start)). The pipeline is held for the whole multiply.
- alu_own is 0 in IDLE and FIX, so the ALU is free for normal use.
- start while busy: ignored, no queueing; the hazard unit prevents it.
- abort in ITER or FIX: state <= IDLE at the next edge; hi/lo keep their previous values; no done pulse.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins, nothing is accepted.
- Reset mid-operation: immediate return to IDLE; hi/lo=0.
- hi/lo change only at FIX; between multiplies they hold their value.

Test Plan:
- Unsigned: start with sgn=0, src_a=3, src_b=5 -> busy for 33 cycles, done pulse once, hi=0x00000000, lo=0x0000000F; alu_own low in IDLE/FIX.
- Unsigned carry: src_a=src_b=0xFFFFFFFF, sgn=0 -> hi=0xFFFFFFFE, lo=0x00000001 (exercises the local carry path).
- Signed: sgn=1, 0xFFFFFFFF * 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Abort: after a completed 3*5, start 7*9 and pulse abort on iteration 10 -> IDLE next cycle, no done, hi=0, lo=15, busy=0.
- Hazard: hilo_rd=1 during a multiply -> stall=1 throughout; start pulsed while busy -> ignored, result equals the first operation's product.
- Reset: drop rst on iteration 20 -> all outputs 0 asynchronously; after release, 2*2 yields lo=4 with normal latency.
